// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// ALU operation codes, opcode constants and datapath mux-select values.
// Optional feature macro: MC_REGIMM_EN (enables the bgez/bgezal REGIMM path).
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_REXEC  = 4'd6,
    ST_RWB    = 4'd7,
    ST_IEXEC  = 4'd8,
    ST_IWB    = 4'd9,
    ST_BEQ    = 4'd10,
    ST_REGIMM = 4'd11,
    ST_JUMP   = 4'd12
  } state_t;

  localparam logic [3:0] ALUOP_ADD   = 4'd0;
  localparam logic [3:0] ALUOP_SUB   = 4'd1;
  localparam logic [3:0] ALUOP_FUNCT = 4'd2;
  localparam logic [3:0] ALUOP_NOR   = 4'd3;
  localparam logic [3:0] ALUOP_OR    = 4'd4;
  localparam logic [3:0] ALUOP_XOR   = 4'd5;
  localparam logic [3:0] ALUOP_AND   = 4'd6;
  localparam logic [3:0] ALUOP_BGEZ  = 4'd7;
  localparam logic [3:0] ALUOP_ADDU  = 4'd8;
  localparam logic [3:0] ALUOP_LUI   = 4'd9;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_JAL    = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_ADDI   = 6'd8;
  localparam logic [5:0] OP_ADDIU  = 6'd9;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_LUI    = 6'd15;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;

  localparam logic [4:0] RT_BGEZ   = 5'd1;
  localparam logic [4:0] RT_BGEZAL = 5'd17;

  localparam logic [1:0] MTR_ALUOUT   = 2'b00;
  localparam logic [1:0] MTR_MDR      = 2'b01;
  localparam logic [1:0] MTR_PC       = 2'b10;
  localparam logic [1:0] RDST_RT      = 2'b00;
  localparam logic [1:0] RDST_RD      = 2'b01;
  localparam logic [1:0] RDST_RA      = 2'b10;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMMSH   = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MC_REGIMM_EN
  localparam logic REGIMM_EN = 1'b1;
`else
  localparam logic REGIMM_EN = 1'b0;
`endif

  // ALU operation for the immediate-arithmetic group, keyed by opcode.
  function automatic logic [3:0] imm_aluop(input logic [5:0] op);
    logic [3:0] code;
    case (op)
      OP_ADDI:  code = ALUOP_ADD;
      OP_ADDIU: code = ALUOP_ADDU;
      OP_ANDI:  code = ALUOP_AND;
      OP_ORI:   code = ALUOP_OR;
      OP_XORI:  code = ALUOP_XOR;
      OP_LUI:   code = ALUOP_LUI;
      default:  code = ALUOP_ADD;
    endcase
    return code;
  endfunction

  // True for the REGIMM sub-ops this core implements (bgez, bgezal).
  function automatic logic is_regimm_rt(input logic [4:0] rt);
    return (rt == RT_BGEZ) || (rt == RT_BGEZAL);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for MemReady and raises
// timeout when the count reaches MEM_TIMEOUT-1.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Wait counter: cleared on state entry, advances on each stalled cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (advance && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign timeout = (count_r == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core (Moore, three processes).
// Optional feature macro: MC_REGIMM_EN adds the bgez/bgezal REGIMM state.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [4:0] RtField,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       IllegalOp,
  output logic       MemError,
  output logic [3:0] State
);

  state_t state_r;
  state_t next_state_s;
  state_t dec_state_s;
  logic   mem_state_s;
  logic   tmo_flag_s;
  logic   abort_s;
  logic   timer_clear_s;
  logic   regimm_ok_s;

  assign mem_state_s   = (state_r == ST_FETCH) || (state_r == ST_MEMRD) || (state_r == ST_MEMWR);
  assign abort_s       = mem_state_s & ~MemReady & tmo_flag_s;
  assign timer_clear_s = (next_state_s != state_r) | abort_s;
  assign regimm_ok_s   = REGIMM_EN & is_regimm_rt(RtField);
  // While reset is held the datapath controls show their FETCH values.
  assign dec_state_s   = reset ? ST_FETCH : state_r;
  assign State         = state_r;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear_s),
    .advance (~MemReady),
    .timeout (tmo_flag_s)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection; a memory timeout always returns to FETCH.
  always_comb begin
    next_state_s = state_r;
    if (reset) begin
      next_state_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH:  next_state_s = abort_s ? ST_FETCH : (MemReady ? ST_DECODE : ST_FETCH);
        ST_DECODE: begin
          case (Opcode)
            OP_LW, OP_SW:     next_state_s = ST_MEMADR;
            OP_RTYPE:         next_state_s = ST_REXEC;
            OP_BEQ:           next_state_s = ST_BEQ;
            OP_J, OP_JAL:     next_state_s = ST_JUMP;
            OP_ADDI, OP_ADDIU, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI: next_state_s = ST_IEXEC;
            OP_REGIMM:        next_state_s = regimm_ok_s ? ST_REGIMM : ST_FETCH;
            default:          next_state_s = ST_FETCH;
          endcase
        end
        ST_MEMADR: next_state_s = (Opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
        ST_MEMRD:  next_state_s = abort_s ? ST_FETCH : (MemReady ? ST_MEMWB : ST_MEMRD);
        ST_MEMWR:  next_state_s = abort_s ? ST_FETCH : (MemReady ? ST_FETCH : ST_MEMWR);
        ST_REXEC:  next_state_s = ST_RWB;
        ST_IEXEC:  next_state_s = ST_IWB;
        default:   next_state_s = ST_FETCH;
      endcase
    end
  end

  // Moore output decode; reset and timeout suppress every write strobe.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = MTR_ALUOUT;
    RegDst      = RDST_RT;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    IllegalOp   = 1'b0;
    MemError    = 1'b0;
    case (dec_state_s)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      ST_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (Opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_JAL,
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: IllegalOp = 1'b0;
          OP_REGIMM: IllegalOp = ~regimm_ok_s;
          default:   IllegalOp = 1'b1;
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_MDR;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        RegWrite = 1'b1;
        RegDst   = RDST_RD;
      end
      ST_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = imm_aluop(Opcode);
      end
      ST_IWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        ALUOp    = imm_aluop(Opcode);
        RegWrite = 1'b1;
      end
      ST_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        if (Opcode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = RDST_RA;
          MemtoReg = MTR_PC;
        end else begin
          RegWrite = 1'b0;
        end
      end
`ifdef MC_REGIMM_EN
      ST_REGIMM: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_BGEZ;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        if (RtField == RT_BGEZAL) begin
          RegWrite = 1'b1;
          RegDst   = RDST_RA;
          MemtoReg = MTR_PC;
        end else begin
          RegWrite = 1'b0;
        end
      end
`endif
      default: begin
        // Unused encodings present the FETCH mux settings with no strobes.
        ALUSrcB = SRCB_FOUR;
      end
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      IllegalOp   = 1'b0;
      MemError    = 1'b0;
    end else if (abort_s) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemError    = 1'b1;
    end else begin
      MemError    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table-driven directed vectors,
// hand-written stall/timeout sequences, and randomized traffic compared
// against an instruction-plan reference model.
module tb_multicycle_control;

  localparam int TMO = 16;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_REXEC = 6, S_RWB = 7, S_IEXEC = 8, S_IWB = 9,
                 S_BEQ = 10, S_REGIMM = 11, S_JUMP = 12;
`ifdef MC_REGIMM_EN
  localparam bit REGIMM_ON = 1'b1;
`else
  localparam bit REGIMM_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, MemReady;
  logic [5:0] Opcode;
  logic [4:0] RtField;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic IllegalOp, MemError;
  logic [1:0] MemtoReg, RegDst, ALUSrcB, PCSource;
  logic [3:0] ALUOp, State;

  always #5 clock = ~clock;

  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .RtField(RtField), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .IllegalOp(IllegalOp), .MemError(MemError), .State(State)
  );

  typedef struct packed {
    logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic [1:0] memtoreg, regdst;
    logic regwrite, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluop;
    logic illegalop, memerror;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic rst; logic [5:0] op; logic [4:0] rt; logic rdy;
    logic [3:0] st; logic [3:0] alu; logic rw; logic [1:0] m2r; logic [1:0] rd;
    logic pwc; logic [1:0] pcs; logic ill;
  } vec_t;

  int passed = 0, total = 0;
  int step = S_FETCH;
  int plan[$];
  int waited = 0;
  outs_t act, exp_o;
  vec_t tbl[$];
  logic [5:0] cur_op;
  logic [4:0] cur_rt;

  function automatic bit legal(input logic [5:0] op, input logic [4:0] rt);
    return (op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43})
        || (REGIMM_ON && op == 6'd1 && (rt == 5'd1 || rt == 5'd17));
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] op);
    case (op)
      6'd9:    return 4'd8;
      6'd12:   return 4'd6;
      6'd13:   return 4'd4;
      6'd14:   return 4'd5;
      6'd15:   return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic outs_t model_out(input logic rst, input logic [5:0] op, input logic [4:0] rt, input logic rdy);
    outs_t o;
    int s;
    bit tmo;
    o = '0;
    o.state = 4'(step);
    s = rst ? S_FETCH : step;
    tmo = !rst && !rdy && (waited == TMO - 1) && (s == S_FETCH || s == S_MEMRD || s == S_MEMWR);
    case (s)
      S_FETCH:  begin o.memread = 1'b1; o.alusrcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy; end
      S_DECODE: begin o.alusrcb = 2'b11; o.illegalop = !legal(op, rt); end
      S_MEMADR: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      S_MEMRD:  begin o.memread = 1'b1; o.iord = 1'b1; end
      S_MEMWB:  begin o.regwrite = 1'b1; o.memtoreg = 2'b01; end
      S_MEMWR:  begin o.memwrite = 1'b1; o.iord = 1'b1; end
      S_REXEC:  begin o.alusrca = 1'b1; o.aluop = 4'd2; end
      S_RWB:    begin o.regwrite = 1'b1; o.regdst = 2'b01; end
      S_IEXEC:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = imm_alu(op); end
      S_IWB:    begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = imm_alu(op); o.regwrite = 1'b1; end
      S_BEQ:    begin o.alusrca = 1'b1; o.aluop = 4'd1; o.pcwritecond = 1'b1; o.pcsource = 2'b01; end
      S_JUMP: begin
        o.pcwrite = 1'b1; o.pcsource = 2'b10;
        if (op == 6'd3) begin o.regwrite = 1'b1; o.regdst = 2'b10; o.memtoreg = 2'b10; end
      end
      S_REGIMM: begin
        o.alusrca = 1'b1; o.aluop = 4'd7; o.pcwritecond = 1'b1; o.pcsource = 2'b01;
        if (rt == 5'd17) begin o.regwrite = 1'b1; o.regdst = 2'b10; o.memtoreg = 2'b10; end
      end
      default: ;
    endcase
    if (tmo || rst) begin
      o.pcwrite = 1'b0; o.pcwritecond = 1'b0; o.memread = 1'b0;
      o.memwrite = 1'b0; o.irwrite = 1'b0; o.regwrite = 1'b0;
    end
    o.memerror = tmo;
    if (rst) o.illegalop = 1'b0;
    return o;
  endfunction

  // Advance the model: each instruction becomes a list of steps after decode.
  task automatic model_step(input logic rst, input logic [5:0] op, input logic [4:0] rt, input logic rdy);
    bit is_mem;
    if (rst) begin
      step = S_FETCH; plan.delete(); waited = 0;
      return;
    end
    is_mem = (step == S_FETCH || step == S_MEMRD || step == S_MEMWR);
    if (is_mem && !rdy) begin
      if (waited == TMO - 1) begin
        step = S_FETCH; plan.delete(); waited = 0;
      end else begin
        waited++;
      end
      return;
    end
    waited = 0;
    if (step == S_FETCH) begin
      step = S_DECODE;
      return;
    end
    if (step == S_DECODE) begin
      plan.delete();
      case (op)
        6'd35: plan = {S_MEMADR, S_MEMRD, S_MEMWB};
        6'd43: plan = {S_MEMADR, S_MEMWR};
        6'd0:  plan = {S_REXEC, S_RWB};
        6'd4:  plan = {S_BEQ};
        6'd2, 6'd3: plan = {S_JUMP};
        6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd15: plan = {S_IEXEC, S_IWB};
        6'd1:  if (legal(op, rt)) plan = {S_REGIMM};
        default: ;
      endcase
    end
    if (plan.size() > 0) step = plan.pop_front();
    else step = S_FETCH;
  endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, a, e);
  endtask

  // One clock: drive inputs, sample at negedge, compare to model, advance.
  task automatic do_cycle(input logic rst, input logic [5:0] op, input logic [4:0] rt, input logic rdy);
    reset = rst; Opcode = op; RtField = rt; MemReady = rdy;
    @(negedge clock);
    act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, IllegalOp, MemError, State};
    exp_o = model_out(rst, op, rt, rdy);
    total++;
    if (act === exp_o) passed++;
    else $display("FAIL model(step %0d op %0d rdy %0b): actual %h required %h", step, op, rdy, act, exp_o);
    @(posedge clock);
    model_step(rst, op, rt, rdy);
    #1;
  endtask

  initial begin
    int pct;
    int ops[17] = '{35, 43, 0, 4, 2, 3, 8, 9, 12, 13, 14, 15, 1, 1, 63, 5, 16};
    int rts[4]  = '{0, 1, 17, 9};

    // rst op rt rdy | state alu rw m2r rd pwc pcs ill
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd0,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd1,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd2,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd3,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd4,  4'd0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  5'd0, 1'b1, 4'd0,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  5'd0, 1'b1, 4'd1,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  5'd0, 1'b1, 4'd6,  4'd2, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd0,  5'd0, 1'b1, 4'd7,  4'd0, 1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd4,  5'd0, 1'b1, 4'd0,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd4,  5'd0, 1'b1, 4'd1,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd4,  5'd0, 1'b1, 4'd10, 4'd1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd0,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd1,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd2,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd35, 5'd0, 1'b1, 4'd3,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 6'd35, 5'd0, 1'b1, 4'd4,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd63, 5'd0, 1'b1, 4'd0,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 6'd63, 5'd0, 1'b1, 4'd1,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 6'd0,  5'd0, 1'b0, 4'd0,  4'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0});

    reset = 1'b1; Opcode = 6'd0; RtField = 5'd0; MemReady = 1'b0;
    @(posedge clock);
    model_step(1'b1, 6'd0, 5'd0, 1'b0);
    #1;

    // Reset state
    do_cycle(1'b1, 6'd0, 5'd0, 1'b1);
    check("reset_state", {28'd0, State}, 32'd0);
    check("reset_memread", {31'd0, MemRead}, 32'd0);

    // Directed vector table
    foreach (tbl[i]) begin
      do_cycle(tbl[i].rst, tbl[i].op, tbl[i].rt, tbl[i].rdy);
      check($sformatf("vec%0d", i),
            {15'd0, act.state, act.aluop, act.regwrite, act.memtoreg, act.regdst,
             act.pcwritecond, act.pcsource, act.illegalop},
            {15'd0, tbl[i].st, tbl[i].alu, tbl[i].rw, tbl[i].m2r, tbl[i].rd,
             tbl[i].pwc, tbl[i].pcs, tbl[i].ill});
    end

    // Fetch stalled three cycles, then a jump
    do_cycle(1'b1, 6'd2, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b0, 6'd2, 5'd0, (i == 3));
      check($sformatf("stall_memread%0d", i), {31'd0, act.memread}, 32'd1);
      check($sformatf("stall_irwrite%0d", i), {31'd0, act.irwrite}, {31'd0, (i == 3)});
      check($sformatf("stall_pcwrite%0d", i), {31'd0, act.pcwrite}, {31'd0, (i == 3)});
    end
    do_cycle(1'b0, 6'd2, 5'd0, 1'b1);
    do_cycle(1'b0, 6'd2, 5'd0, 1'b1);
    check("jump_pcwrite", {31'd0, act.pcwrite}, 32'd1);
    check("jump_pcsource", {30'd0, act.pcsource}, 32'd2);

    // Store with memory never ready: timeout on the 16th wait cycle
    do_cycle(1'b0, 6'd43, 5'd0, 1'b1);
    do_cycle(1'b0, 6'd43, 5'd0, 1'b1);
    do_cycle(1'b0, 6'd43, 5'd0, 1'b1);
    for (int i = 0; i < TMO; i++) begin
      do_cycle(1'b0, 6'd43, 5'd0, 1'b0);
      check($sformatf("sw_memerror%0d", i), {31'd0, act.memerror}, {31'd0, (i == TMO - 1)});
      check($sformatf("sw_memwrite%0d", i), {31'd0, act.memwrite}, {31'd0, (i != TMO - 1)});
    end
    do_cycle(1'b0, 6'd43, 5'd0, 1'b1);
    check("after_tmo_state", {28'd0, act.state}, 32'd0);
    check("after_tmo_memwrite", {31'd0, act.memwrite}, 32'd0);

    // Randomized traffic against the reference model
    cur_op = 6'd43; cur_rt = 5'd0; pct = 100;
    for (int n = 0; n < 3000; n++) begin
      logic rdy, rst;
      if (n % 250 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 100;
          1: pct = 75;
          2: pct = 40;
          default: pct = 3;
        endcase
      end
      rdy = ($urandom_range(0, 99) < pct);
      rst = ($urandom_range(0, 199) == 0);
      if (step == S_FETCH) begin
        cur_op = 6'(ops[$urandom_range(0, 16)]);
        cur_rt = 5'(rts[$urandom_range(0, 3)]);
      end
      do_cycle(rst, cur_op, cur_rt, rdy);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
